// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: register addresses and edge-type codes.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_bit_filter.sv
// One input bit: SYNC_STAGES-deep synchroniser, optionally followed by a debouncer.
// The debouncer is built only when PIO_IN_DEBOUNCE_EN is defined; otherwise d_o is the last sync stage.
module pio_in_bit_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic d_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          synced;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Stable only follows the synced bit after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == CNT_TC) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign d_o = stable_q;
`else
  assign d_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture, interrupt mask and level IRQ.
// Define PIO_IN_DEBOUNCE_EN to add a per-bit debouncer behind the synchroniser.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wd;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_in_bit_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .reset_n(reset_n),
      .din_i  (in_port[g]),
      .d_o    (d[g])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = ~d & d_prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = d ^ d_prev_q;
    end else begin
      edge_det = d & ~d_prev_q;
    end
  end

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // A fresh edge is ORed in after the W1C clear so a same-cycle event survives.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && address == PIO_ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == PIO_ADDR_EDGE) begin
      edge_d = edge_q & ~writedata[WIDTH-1:0];
    end
    edge_d = edge_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = d;
      PIO_ADDR_RSVD: readdata_d = '0;
      PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev_q   <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      d_prev_q   <= d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq (WIDTH=4, rising edges) against a queue-based reference model.
module tb_pio_in_edge_irq;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 16;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DB = DC;
`else
  localparam int DB = 0;
`endif
  // Edges from an in_port change until d shows it; capture lands one edge later.
  localparam int LAT_D = SS + DB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int total = 0;
  int bad   = 0;

  pio_in_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: sampled-input history queue, debounce run lengths, register images.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_d, m_dp, m_edge, m_mask, m_stable;
  logic [31:0]  m_rd;
  int           run_len[W];

  function automatic logic m_irq();
    return |(m_edge & m_mask);
  endfunction

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < SS; i++) hist.push_back('0);
    m_d = '0; m_dp = '0; m_edge = '0; m_mask = '0; m_stable = '0; m_rd = '0;
    for (int i = 0; i < W; i++) run_len[i] = 0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] rise, clr, synced, nd;
    logic [31:0]  rd;
    rd = '0;
    if (address == 2'd0) rd[W-1:0] = m_d;
    if (address == 2'd2) rd[W-1:0] = m_mask;
    if (address == 2'd3) rd[W-1:0] = m_edge;
    rise = m_d & ~m_dp;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_edge = (m_edge & ~clr) | rise;
    hist.push_back(in_port);
    void'(hist.pop_front());
    synced = hist[0];
    nd = synced;
    if (DB != 0) begin
      for (int i = 0; i < W; i++) begin
        if (synced[i] != m_stable[i]) begin
          run_len[i]++;
          if (run_len[i] == DC) begin
            m_stable[i] = synced[i];
            run_len[i] = 0;
          end
        end else begin
          run_len[i] = 0;
        end
      end
      nd = m_stable;
    end
    m_dp = m_d;
    m_d  = nd;
    m_rd = rd;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic test_reset();
    logic [1:0] addrs[3];
    addrs = '{2'd0, 2'd2, 2'd3};
    reset_n = 1'b0; in_port = '0; address = '0; bus_idle();
    model_reset();
    #23;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", readdata); end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i]);
      total++;
      if (readdata !== 32'h0 || readdata !== m_rd) begin
        bad++; $display("FAIL reset_read a=%0d got=%h exp=0", addrs[i], readdata);
      end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_mask_irq();
    bus_write(2'd2, 32'h5);
    in_port = 4'b0001;
    for (int k = 1; k <= LAT_D + 1; k++) begin
      tick();
      total++;
      if (irq !== (k == LAT_D + 1) || irq !== m_irq()) begin
        bad++; $display("FAIL irq_latency edge=%0d got=%b exp=%b", k, irq, (k == LAT_D + 1));
      end
    end
    bus_read(2'd3);
    total++; if (readdata !== 32'h1) begin bad++; $display("FAIL edgecapt_b0 got=%h exp=1", readdata); end
    bus_read(2'd0);
    total++; if (readdata !== 32'h1) begin bad++; $display("FAIL data_b0 got=%h exp=1", readdata); end
  endtask

  task automatic test_masked_clear();
    in_port = 4'b0011;
    for (int k = 0; k < LAT_D + 2; k++) tick();
    bus_read(2'd3);
    total++; if (readdata !== 32'h3) begin bad++; $display("FAIL edgecapt_b01 got=%h exp=3", readdata); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    bus_write(2'd3, 32'h1);
    total++; if (irq !== 1'b0 || irq !== m_irq()) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_read(2'd3);
    total++; if (readdata !== 32'h2) begin bad++; $display("FAIL edgecapt_after_w1c got=%h exp=2", readdata); end
  endtask

  task automatic test_set_wins();
    in_port = 4'b0010;
    for (int k = 0; k < LAT_D + 3; k++) tick();
    bus_write(2'd3, 32'hF);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pre_collide got=%b exp=0", irq); end
    in_port = 4'b0011;
    for (int k = 0; k < LAT_D; k++) tick();
    bus_write(2'd3, 32'h1);
    total++; if (irq !== 1'b1 || irq !== m_irq()) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
    bus_read(2'd3);
    total++; if (readdata !== 32'h1) begin bad++; $display("FAIL set_wins_capt got=%h exp=1", readdata); end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = (DB != 0) ? $urandom_range(1, 40) : $urandom_range(1, 6);
      end
      hold--;
      address    = 2'($urandom);
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      tick();
      total++;
      if (readdata !== m_rd || irq !== m_irq()) begin
        bad++;
        $display("FAIL random c=%0d rd=%h exp=%h irq=%b exp=%b", c, readdata, m_rd, irq, m_irq());
      end
    end
    bus_idle();
  endtask

`ifdef PIO_IN_DEBOUNCE_EN
  task automatic test_debounce();
    in_port = '0;
    for (int k = 0; k < LAT_D + 4; k++) tick();
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    in_port = 4'b0100;
    for (int k = 0; k < 10; k++) tick();
    in_port = '0;
    for (int k = 0; k < LAT_D + 4; k++) begin
      tick();
      total++;
      if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL glitch_data got=%h exp=0", readdata); end
    end
    bus_read(2'd3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL glitch_capt got=%h exp=0", readdata); end
    address = 2'd0;
    in_port = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (readdata[2] !== (k >= SS + DC + 1) || readdata !== m_rd) begin
        bad++; $display("FAIL pulse_data edge=%0d got=%h exp=%h", k, readdata, m_rd);
      end
    end
    in_port = '0;
    for (int k = 0; k < LAT_D + 4; k++) tick();
    bus_read(2'd3);
    total++; if (readdata !== 32'h4) begin bad++; $display("FAIL pulse_capt got=%h exp=4", readdata); end
  endtask
`endif

  task automatic test_reset_mid();
    bus_write(2'd2, 32'h1);
    in_port = '0;
    for (int k = 0; k < LAT_D + 3; k++) tick();
    bus_write(2'd3, 32'hF);
    in_port = 4'b0001;
    for (int k = 0; k < LAT_D + 2; k++) tick();
    address = 2'd3;
    tick();
    total++; if (irq !== 1'b1 || readdata !== 32'h1) begin bad++; $display("FAIL pre_reset irq=%b rd=%h exp irq=1 rd=1", irq, readdata); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL async_rd got=%h exp=0", readdata); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < LAT_D + 3; k++) tick();
    bus_read(2'd3);
    total++; if (readdata !== 32'h1 || readdata !== m_rd) begin bad++; $display("FAIL held_high_capt got=%h exp=1", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_mask_reset got=%b exp=0", irq); end
    bus_write(2'd3, 32'h1);
    for (int k = 0; k < 10; k++) tick();
    bus_read(2'd3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL single_capt got=%h exp=0", readdata); end
  endtask

  initial begin
    test_reset();
    test_mask_irq();
    test_masked_clear();
    test_set_wins();
    test_random();
`ifdef PIO_IN_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
